// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port instruction RAM between the
// fetch stage and a debug/loader port, with bounded debug starvation and burst locking.
module imem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_stall,
  output logic [31:0] if_data,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic        dbg_lock,
  input  logic [15:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        locked
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_LOCK  = 1'b1;
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_nxt_s;
  logic             if_gnt_s;
  logic             dbg_gnt_s;
  logic             dbg_rvalid_r;
  logic [31:0]      dbg_rdata_r;
  logic             unused_s;

  // Upper fetch address bits are outside the 64K-word instruction memory.
  assign unused_s = ^if_addr[31:16];

  // Grant selection: a held lock shuts fetch out, otherwise fetch wins until debug has waited long enough.
  always_comb begin
    if_gnt_s  = 1'b0;
    dbg_gnt_s = 1'b0;
    if ((state_r == ST_LOCK) && dbg_lock) begin
      dbg_gnt_s = dbg_req;
    end else if (if_req && dbg_req) begin
      if (starve_cnt_r == LIMIT_C) begin
        dbg_gnt_s = 1'b1;
      end else begin
        if_gnt_s = 1'b1;
      end
    end else begin
      if_gnt_s  = if_req;
      dbg_gnt_s = dbg_req;
    end
  end

  // Next lock state and debug starvation count.
  always_comb begin
    state_nxt_s  = ST_FETCH;
    starve_nxt_s = starve_cnt_r;
    case (state_r)
      ST_FETCH: begin
        if (dbg_gnt_s && dbg_lock) begin
          state_nxt_s = ST_LOCK;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_LOCK: begin
        if (dbg_lock) begin
          state_nxt_s = ST_LOCK;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      default: begin
        state_nxt_s = ST_FETCH;
      end
    endcase
    if (dbg_gnt_s || !dbg_req) begin
      starve_nxt_s = {CNT_W{1'b0}};
    end else if (if_gnt_s) begin
      starve_nxt_s = starve_cnt_r + CNT_W'(1);
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r      <= ST_FETCH;
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_nxt_s;
    end
  end

  // Debug read return: one-cycle valid pulse, data held between reads.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dbg_rvalid_r <= 1'b0;
      dbg_rdata_r  <= 32'h0000_0000;
    end else begin
      dbg_rvalid_r <= dbg_gnt_s & ~dbg_we;
      if (dbg_gnt_s && !dbg_we) begin
        dbg_rdata_r <= mem_rdata;
      end else begin
        dbg_rdata_r <= dbg_rdata_r;
      end
    end
  end

  assign if_gnt     = if_gnt_s;
  assign dbg_gnt    = dbg_gnt_s;
  assign if_stall   = if_req & ~if_gnt_s;
  assign if_data    = if_gnt_s ? mem_rdata : 32'h0000_0000;
  assign mem_cs     = if_gnt_s | dbg_gnt_s;
  assign mem_we     = dbg_gnt_s & dbg_we;
  assign mem_addr   = if_gnt_s ? if_addr[15:0] : (dbg_gnt_s ? dbg_addr : 16'h0000);
  assign mem_wdata  = (dbg_gnt_s && dbg_we) ? dbg_wdata : 32'h0000_0000;
  assign dbg_rvalid = dbg_rvalid_r;
  assign dbg_rdata  = dbg_rdata_r;
  assign locked     = (state_r == ST_LOCK);

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_imem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        clr, if_req, dbg_req, dbg_we, dbg_lock;
  logic [31:0] if_addr, dbg_wdata, mem_rdata, if_data, dbg_rdata, mem_wdata;
  logic [15:0] dbg_addr, mem_addr;
  logic        if_gnt, if_stall, dbg_gnt, dbg_rvalid, mem_cs, mem_we, locked;

  logic [31:0] mem_img [0:65535];
  assign mem_rdata = mem_img[mem_addr];

  always #5 clk = ~clk;

  imem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .clr(clr), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_stall(if_stall), .if_data(if_data), .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_lock(dbg_lock), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .locked(locked)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: lock ownership, cycles debug has waited behind fetch, read return.
  bit          m_locked;
  int          m_wait;
  bit          m_rv;
  logic [31:0] m_rdata;
  bit          dbg_pending;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr, dw, dl;
    logic [15:0] da;
    logic [31:0] wd;
    logic        e_if, e_dbg;
    logic [15:0] e_addr;
    logic        e_rv;
    logic [31:0] e_rd;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_wait   = 0;
    m_rv     = 1'b0;
    m_rdata  = 32'h0;
  endtask

  task automatic drv(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic dl, input logic [15:0] da, input logic [31:0] wd);
    if_req = ir; if_addr = ia; dbg_req = dr; dbg_we = dw; dbg_lock = dl;
    dbg_addr = da; dbg_wdata = wd;
  endtask

  // One clock: check every output against the model before the edge, then advance the model.
  task automatic step();
    logic        eif, edbg, wen;
    logic [15:0] eaddr, wa;
    logic [31:0] cap, wd;
    if (clk) @(negedge clk);
    if (m_locked && dbg_lock) begin
      eif = 1'b0; edbg = dbg_req;
    end else if (if_req && dbg_req) begin
      edbg = (m_wait >= LIMIT); eif = !edbg;
    end else begin
      eif = if_req; edbg = dbg_req;
    end
    eaddr = eif ? if_addr[15:0] : (edbg ? dbg_addr : 16'h0);
    chk("if_gnt", if_gnt, eif);
    chk("dbg_gnt", dbg_gnt, edbg);
    chk("if_stall", if_stall, if_req && !eif);
    chk("if_data", if_data, eif ? mem_img[if_addr[15:0]] : 32'h0);
    chk("mem_cs", mem_cs, eif || edbg);
    chk("mem_we", mem_we, edbg && dbg_we);
    chk("mem_addr", mem_addr, eaddr);
    chk("mem_wdata", mem_wdata, (edbg && dbg_we) ? dbg_wdata : 32'h0);
    chk("dbg_rvalid", dbg_rvalid, m_rv);
    chk("dbg_rdata", dbg_rdata, m_rdata);
    chk("locked", locked, m_locked);
    cap = mem_img[dbg_addr];
    wen = mem_cs && mem_we; wa = mem_addr; wd = mem_wdata;
    @(posedge clk);
    if (wen) mem_img[wa] = wd;
    if (clr) begin
      model_reset();
    end else begin
      m_rv = edbg && !dbg_we;
      if (m_rv) m_rdata = cap;
      if (edbg || !dbg_req) m_wait = 0;
      else if (eif) m_wait = m_wait + 1;
      m_locked = m_locked ? dbg_lock : (edbg && dbg_lock);
    end
    dbg_pending = dbg_req && !edbg;
    #1;
  endtask

  initial begin
    int we_cnt;
    for (int i = 0; i < 65536; i++) mem_img[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    mem_img[16'h0010] = 32'hDEAD_BEEF;
    dbg_pending = 1'b0;
    model_reset();
    clr = 1'b1;
    drv(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);

    // Reset state, and fetch from address 0 while reset is still asserted.
    @(negedge clk);
    chk("rst_locked", locked, 1'b0);
    chk("rst_rvalid", dbg_rvalid, 1'b0);
    chk("rst_rdata", dbg_rdata, 32'h0);
    chk("rst_if_gnt", if_gnt, 1'b1);
    chk("rst_if_data", if_data, mem_img[0]);
    step();
    clr = 1'b0;

    vecs[0] = '{1'b1, 32'h0001_0005, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 16'h0005, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b1, 16'h0010, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 16'h0020, 32'h1234_5678, 1'b0, 1'b1, 16'h0020, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0, 1'b0, 1'b1, 16'h0020, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'hFFFF_0020, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 16'h0020, 1'b1, 32'h1234_5678};
    for (int i = 0; i < 7; i++) begin
      drv(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].dl, vecs[i].da, vecs[i].wd);
      @(negedge clk);
      chk("vec_if_gnt", if_gnt, vecs[i].e_if);
      chk("vec_dbg_gnt", dbg_gnt, vecs[i].e_dbg);
      chk("vec_mem_addr", mem_addr, vecs[i].e_addr);
      chk("vec_rvalid", dbg_rvalid, vecs[i].e_rv);
      if (vecs[i].e_rv) chk("vec_rdata", dbg_rdata, vecs[i].e_rd);
      step();
    end

    // Starvation bound: four fetch wins, then debug takes the fifth cycle.
    drv(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 16'h0030, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("starve_if_gnt", if_gnt, c < 4);
      chk("starve_dbg_gnt", dbg_gnt, c == 4);
      chk("starve_if_stall", if_stall, c == 4);
      step();
    end
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    step();

    // Back-to-back debug reads give back-to-back valid pulses.
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'(k + 8), 32'h0);
      @(negedge clk);
      chk("b2b_rvalid", dbg_rvalid, k > 0);
      step();
    end
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk("b2b_rvalid_last", dbg_rvalid, 1'b1);
    chk("b2b_rdata_last", dbg_rdata, mem_img[10]);
    step();
    @(negedge clk);
    chk("b2b_rvalid_end", dbg_rvalid, 1'b0);
    step();

    // Locked write burst to words 0..3 while fetch keeps requesting.
    we_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      drv(1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 16'(c < 4 ? 0 : c - 4), 32'hA000_0000 + 32'(c < 4 ? 0 : c - 4));
      @(negedge clk);
      if (mem_we) we_cnt++;
      chk("burst_if_gnt", if_gnt, c < 4);
      chk("burst_locked", locked, c > 4);
      if (c >= 4) chk("burst_if_stall", if_stall, 1'b1);
      step();
    end
    chk("burst_we_count", we_cnt, 4);
    drv(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk("release_if_gnt", if_gnt, 1'b1);
    chk("release_locked_same", locked, 1'b1);
    step();
    @(negedge clk);
    chk("release_locked_next", locked, 1'b0);
    step();
    for (int k = 0; k < 4; k++) chk("burst_mem", mem_img[k], 32'hA000_0000 + 32'(k));

    // Reset in the middle of a locked read burst.
    drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0010, 32'h0);
    step();
    drv(1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 16'h0011, 32'h0);
    @(negedge clk);
    chk("abort_locked", locked, 1'b1);
    chk("abort_dbg_gnt", dbg_gnt, 1'b1);
    step();
    chk("abort_rvalid_pre", dbg_rvalid, 1'b1);
    clr = 1'b1;
    model_reset();
    #1;
    chk("abort_locked_clr", locked, 1'b0);
    chk("abort_rvalid_clr", dbg_rvalid, 1'b0);
    drv(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    clr = 1'b0;
    @(negedge clk);
    chk("abort_if_gnt", if_gnt, 1'b1);
    step();

    // Randomized traffic; debug holds its request until granted, occasional reset pulses.
    for (int n = 0; n < 800; n++) begin
      if (clr) begin
        clr = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        clr = 1'b1;
        model_reset();
      end
      if (!dbg_pending) begin
        dbg_req   = ($urandom_range(0, 2) != 0);
        dbg_we    = $urandom_range(0, 1) == 1;
        dbg_lock  = ($urandom_range(0, 3) == 0);
        dbg_addr  = 16'($urandom_range(0, 31));
        dbg_wdata = $urandom;
      end
      if_req  = ($urandom_range(0, 3) != 0);
      if_addr = {16'($urandom), 16'($urandom_range(0, 31))};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive fetch grants while a debug request waits.
REQ-002 clk  input  1  single system clock; all state on posedge clk.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 if_req  input  1  fetch stage requests an instruction read this cycle.
REQ-005 if_addr  input  32  fetch word address; only bits [15:0] reach memory.
REQ-006 if_gnt  output  1  fetch access performed this cycle (combinational).
REQ-007 if_stall  output  1  if_req & ~if_gnt; drives the fetch-stage stall input.
REQ-008 if_data  output  32  mem_rdata when if_gnt, else 32'h00000000.
REQ-009 dbg_req  input  1  debug/loader requests an access; held high until dbg_gnt.
REQ-010 dbg_we  input  1  1: write, 0: read.
REQ-011 dbg_lock  input  1  request burst ownership of memory.
REQ-012 dbg_addr  input  16  debug word address.
REQ-013 dbg_wdata  input  32  debug write data.
REQ-014 dbg_gnt  output  1  debug access performed this cycle (combinational).
REQ-015 dbg_rvalid  output  1  registered; high one cycle after a granted debug read.
REQ-016 dbg_rdata  output  32  registered read data, valid while dbg_rvalid.
REQ-017 mem_cs / mem_we / mem_addr[15:0] / mem_wdata[31:0]  outputs  memory port, combinational from winner.
REQ-018 mem_rdata  input  32  combinational read data from the instruction memory.
REQ-019 locked  output  1  registered; 1 while in state ST_LOCK.

Function
REQ-020 At most one of if_gnt, dbg_gnt SHALL be high in any cycle; mem_cs = if_gnt | dbg_gnt.
REQ-021 mem_we SHALL equal dbg_gnt & dbg_we; fetch accesses are always reads.
REQ-022 Idle cycle (no grant): mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-023 States: ST_FETCH (normal arbitration), ST_LOCK (debug burst ownership).
REQ-024 ST_FETCH, only one requester: that requester granted same cycle.
REQ-025 ST_FETCH, both request, starve_cnt < STARVE_LIMIT: fetch granted, starve_cnt increments.
REQ-026 ST_FETCH, both request, starve_cnt == STARVE_LIMIT: debug granted, fetch stalled.
REQ-027 starve_cnt SHALL clear on any dbg_gnt or any cycle with dbg_req=0; never exceeds STARVE_LIMIT.
REQ-028 ST_FETCH -> ST_LOCK at the edge ending a cycle with dbg_gnt=1 and dbg_lock=1.
REQ-029 ST_LOCK, dbg_lock=1: fetch never granted; debug granted whenever dbg_req=1; no grant otherwise.
REQ-030 ST_LOCK, dbg_lock=0: REQ-024..026 arbitration applies that cycle; next state ST_FETCH.
REQ-031 dbg_rvalid SHALL be 1 exactly in the cycle after dbg_gnt & ~dbg_we, with dbg_rdata = mem_rdata captured at that grant; dbg_rdata holds otherwise.
REQ-032 Back-to-back debug reads SHALL produce back-to-back dbg_rvalid pulses, one per grant.
REQ-033 Writes SHALL NOT assert dbg_rvalid.
REQ-034 if_data SHALL be valid in the grant cycle (zero latency), matching the combinational fetch path.

Reset
REQ-035 While clr=1, asynchronously: state=ST_FETCH, starve_cnt=0, dbg_rvalid=0, dbg_rdata=0, locked=0.
REQ-036 During clr=1 grants SHALL still follow REQ-024..026 from the reset state, so fetch can read address 0 in the reset cycle.
REQ-037 clr asserted mid-burst SHALL abort the lock; a pending dbg_rvalid is dropped.

Verification
REQ-038 if_req=1 only, if_addr=32'h00010005 -> if_gnt=1, mem_addr=16'h0005, if_stall=0, if_data=mem_rdata.
REQ-039 if_req=1 and dbg_req=1 held, STARVE_LIMIT=4 -> fetch granted cycles 0..3, debug granted cycle 4, if_stall=1 only in cycle 4.
REQ-040 Debug read addr 16'h0010, mem holds 32'hDEADBEEF -> dbg_gnt cycle N, dbg_rvalid=1 and dbg_rdata=32'hDEADBEEF cycle N+1.
REQ-041 dbg_lock=1 write burst to 16'h0000..16'h0003 with if_req=1 -> locked=1 from second cycle, if_stall=1 throughout, mem_we=1 on four grants; dbg_lock=0 -> fetch granted same cycle, locked=0 next.
REQ-042 clr pulsed while locked=1 and a read granted -> locked=0, dbg_rvalid=0 immediately, starve_cnt=0, fetch granted next cycle.
